// File: rtl/mul_arbiter.sv
// Round-robin arbiter sharing one pipelined 8x8 multiplier between requesters.
// A {valid,id} tag pipe tracks each issued op so its product returns tagged.
module mul_arbiter #(
  parameter int N_REQ   = 4,
  parameter int MUL_LAT = 1,
  localparam int ID_W   = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [N_REQ-1:0]   req_valid,
  output logic [N_REQ-1:0]   req_ready,
  input  logic [8*N_REQ-1:0] req_a,
  input  logic [8*N_REQ-1:0] req_b,
  output logic [7:0]         mul_a,
  output logic [7:0]         mul_b,
  input  logic [15:0]        mul_p,
  output logic               rsp_valid,
  output logic [ID_W-1:0]    rsp_id,
  output logic [15:0]        rsp_p,
  output logic               busy
);

  typedef struct packed {
    logic            v;
    logic [ID_W-1:0] id;
  } tag_t;

  // ptr_q is the highest-priority index, i.e. last_granted + 1
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [ID_W-1:0]    gnt_idx;
  logic               gnt_any;
  logic               hs;
  logic [7:0]         mul_a_q, mul_b_q;
  tag_t [MUL_LAT:0]   tag_q;
  logic               rsp_valid_q;
  logic [ID_W-1:0]    rsp_id_q;
  logic [15:0]        rsp_p_q;
  logic               inflight;

  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      logic [ID_W:0] s;
      s = {1'b0, ptr_q} + (ID_W+1)'(k);
      if (s >= (ID_W+1)'(N_REQ))
        s = s - (ID_W+1)'(N_REQ);
      if (!gnt_any && req_valid[s[ID_W-1:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = s[ID_W-1:0];
      end
    end
  end

  assign hs = en & gnt_any & ~rst;

  always_comb begin
    req_ready = '0;
    if (hs)
      req_ready = N_REQ'(1) << gnt_idx;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (hs) begin
      if (gnt_idx == ID_W'(N_REQ - 1))
        ptr_d = '0;
      else
        ptr_d = gnt_idx + ID_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q       <= '0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      tag_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_p_q     <= '0;
    end else begin
      ptr_q <= ptr_d;
      if (hs) begin
        mul_a_q <= req_a[{gnt_idx, 3'b000} +: 8];
        mul_b_q <= req_b[{gnt_idx, 3'b000} +: 8];
      end
      // head stage lines up with mul_p for the same op
      tag_q <= {tag_q[MUL_LAT-1:0], tag_t'{v: hs, id: gnt_idx}};
      rsp_valid_q <= tag_q[MUL_LAT].v;
      if (tag_q[MUL_LAT].v) begin
        rsp_id_q <= tag_q[MUL_LAT].id;
        rsp_p_q  <= mul_p;
      end
    end
  end

  always_comb begin
    inflight = 1'b0;
    for (int i = 0; i <= MUL_LAT; i++)
      inflight = inflight | tag_q[i].v;
  end

  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_p     = rsp_p_q;
  assign busy      = inflight | rsp_valid_q;

endmodule

// File: tb/tb_mul_arbiter.sv
// Bench for mul_arbiter: MUL_LAT=1 and MUL_LAT=3 instances share stimulus
// and are checked every cycle against a schedule-based reference model.
module tb_mul_arbiter;
  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;

  logic [3:0]  rdy0, rdy1;
  logic [7:0]  ma0, ma1, mb0, mb1;
  logic [15:0] mp0, mp1;
  logic        rv0, rv1, bz0, bz1;
  logic [1:0]  rid0, rid1;
  logic [15:0] rp0, rp1;
  logic [15:0] p3 [3];

  always #5 clk = ~clk;

  mul_arbiter #(.N_REQ(4), .MUL_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst), .en(en), .req_valid(req_valid),
    .req_ready(rdy0), .req_a(req_a), .req_b(req_b),
    .mul_a(ma0), .mul_b(mb0), .mul_p(mp0),
    .rsp_valid(rv0), .rsp_id(rid0), .rsp_p(rp0), .busy(bz0));

  mul_arbiter #(.N_REQ(4), .MUL_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst), .en(en), .req_valid(req_valid),
    .req_ready(rdy1), .req_a(req_a), .req_b(req_b),
    .mul_a(ma1), .mul_b(mb1), .mul_p(mp1),
    .rsp_valid(rv1), .rsp_id(rid1), .rsp_p(rp1), .busy(bz1));

  // multiplier models with 1 and 3 cycles of latency
  initial mp0 = '0;
  always @(posedge clk) mp0 <= 16'(ma0) * 16'(mb0);
  initial begin p3[0] = '0; p3[1] = '0; p3[2] = '0; end
  always @(posedge clk) begin
    p3[0] <= 16'(ma1) * 16'(mb1);
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign mp1 = p3[2];

  int lat [2] = '{1, 3};
  int cyc = 0;
  int last_g;
  bit sv [2][16];
  int sid [2][16];
  int sp [2][16];
  int pend [2];
  int last_id [2];
  int last_p [2];
  int exp_ma, exp_mb;
  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  function automatic int exp_grant();
    if (rst || !en) return -1;
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (last_g + k) % N;
      if (req_valid[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    last_g = N - 1;
    exp_ma = 0;
    exp_mb = 0;
    for (int k = 0; k < 2; k++) begin
      pend[k] = 0;
      last_id[k] = 0;
      last_p[k] = 0;
      for (int s = 0; s < 16; s++) sv[k][s] = 1'b0;
    end
  endtask

  task automatic half1();
    int g, er, slot;
    int a_rdy [2], a_ma [2], a_mb [2], a_rv [2], a_id [2], a_p [2], a_bz [2];
    @(negedge clk);
    a_rdy[0] = rdy0; a_rdy[1] = rdy1;
    a_ma[0] = ma0;   a_ma[1] = ma1;
    a_mb[0] = mb0;   a_mb[1] = mb1;
    a_rv[0] = rv0;   a_rv[1] = rv1;
    a_id[0] = rid0;  a_id[1] = rid1;
    a_p[0] = rp0;    a_p[1] = rp1;
    a_bz[0] = bz0;   a_bz[1] = bz1;
    g = exp_grant();
    er = (g < 0) ? 0 : (1 << g);
    slot = cyc % 16;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("ready%0d", k), a_rdy[k], er);
      chk($sformatf("mul_a%0d", k), a_ma[k], exp_ma);
      chk($sformatf("mul_b%0d", k), a_mb[k], exp_mb);
      chk($sformatf("busy%0d", k), a_bz[k], int'(pend[k] > 0));
      if (sv[k][slot]) begin
        chk($sformatf("rsp_valid%0d", k), a_rv[k], 1);
        chk($sformatf("rsp_id%0d", k), a_id[k], sid[k][slot]);
        chk($sformatf("rsp_p%0d", k), a_p[k], sp[k][slot]);
        last_id[k] = sid[k][slot];
        last_p[k] = sp[k][slot];
        sv[k][slot] = 1'b0;
        pend[k]--;
      end else begin
        chk($sformatf("rsp_valid%0d", k), a_rv[k], 0);
        chk($sformatf("rsp_hold_id%0d", k), a_id[k], last_id[k]);
        chk($sformatf("rsp_hold_p%0d", k), a_p[k], last_p[k]);
      end
    end
  endtask

  task automatic half2();
    int g, a, b, slot;
    @(posedge clk);
    g = exp_grant();
    if (g >= 0) begin
      a = int'(req_a[g*8 +: 8]);
      b = int'(req_b[g*8 +: 8]);
      exp_ma = a;
      exp_mb = b;
      for (int k = 0; k < 2; k++) begin
        slot = (cyc + lat[k] + 2) % 16;
        sv[k][slot] = 1'b1;
        sid[k][slot] = g;
        sp[k][slot] = a * b;
        pend[k]++;
      end
      last_g = g;
    end
    cyc++;
    #1;
  endtask

  task automatic step();
    half1();
    half2();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    step();
    rst = 1'b0;
  endtask

  function automatic logic [7:0] pick();
    case ($urandom_range(0, 4))
      0: return 8'd0;
      1: return 8'hFF;
      2: return 8'd1;
      default: return 8'($urandom);
    endcase
  endfunction

  task automatic rnd_ops();
    for (int i = 0; i < N; i++) begin
      req_a[i*8 +: 8] = pick();
      req_b[i*8 +: 8] = pick();
    end
  endtask

  initial begin
    int cnt0, cnt1;
    model_reset();
    half1();
    chk("rst_ready", int'(rdy0), 0);
    chk("rst_busy", int'(bz0), 0);
    half2();
    step();
    rst = 1'b0;

    // single op, latency check
    en = 1'b1;
    req_valid = 4'b0001;
    req_a[7:0] = 8'd12;
    req_b[7:0] = 8'd13;
    half1();
    chk("t1_ready", int'(rdy0), 1);
    half2();
    req_valid = '0;
    for (int j = 1; j <= 6; j++) begin
      half1();
      if (j == 3) begin
        chk("t1_rv", int'(rv0), 1);
        chk("t1_id", int'(rid0), 0);
        chk("t1_p", int'(rp0), 156);
      end
      if (j == 4) chk("t1_pulse", int'(rv0), 0);
      if (j == 5) begin
        chk("t1_rv_l3", int'(rv1), 1);
        chk("t1_p_l3", int'(rp1), 156);
      end
      if (j == 6) chk("t1_pulse_l3", int'(rv1), 0);
      half2();
    end

    // all four requesting: rotating order, back-to-back responses
    do_reset();
    req_valid = 4'hF;
    for (int j = 0; j < 8; j++) begin
      rnd_ops();
      half1();
      chk("t2_order", int'(rdy0), 1 << (j % 4));
      if (j >= 3) begin
        chk("t2_rv", int'(rv0), 1);
        chk("t2_id", int'(rid0), (j - 3) % 4);
      end
      half2();
    end

    // wrap from last grant 3
    req_valid = 4'b1010;
    for (int j = 0; j < 3; j++) begin
      half1();
      chk("t3_wrap", int'(rdy0), (j % 2 == 0) ? 2 : 8);
      half2();
    end
    req_valid = '0;
    repeat (8) step();

    // operand extremes
    do_reset();
    req_valid = 4'b0001;
    req_a[7:0] = 8'd255; req_b[7:0] = 8'd255; step();
    req_a[7:0] = 8'd0;   req_b[7:0] = 8'd200; step();
    req_a[7:0] = 8'd1;   req_b[7:0] = 8'd255; step();
    req_valid = '0;
    half1(); chk("t4_ff", int'(rp0), 16'hFE01); half2();
    half1(); chk("t4_zero", int'(rp0), 0); half2();
    half1(); chk("t4_one", int'(rp0), 16'h00FF); half2();
    repeat (4) step();

    // en drop with requests held
    do_reset();
    req_valid = 4'hF;
    rnd_ops();
    cnt0 = 0;
    cnt1 = 0;
    for (int j = 0; j < 12; j++) begin
      if (j == 3) en = 1'b0;
      half1();
      cnt0 += int'(rv0);
      cnt1 += int'(rv1);
      if (j >= 3) chk("t5_noready", int'(rdy0), 0);
      if (j == 6) chk("t5_busy", int'(bz0), 0);
      if (j == 8) chk("t5_busy_l3", int'(bz1), 0);
      half2();
    end
    chk("t5_count", cnt0, 3);
    chk("t5_count_l3", cnt1, 3);
    req_valid = '0;
    en = 1'b1;

    // reset with ops in flight
    do_reset();
    req_valid = 4'b0001;
    rnd_ops();
    step();
    step();
    req_valid = '0;
    rst = 1'b1;
    model_reset();
    #1;
    chk("t6_rv", int'(rv0), 0);
    chk("t6_busy", int'(bz0), 0);
    chk("t6_busy_l3", int'(bz1), 0);
    step();
    rst = 1'b0;
    req_valid = 4'b0101;
    half1();
    chk("t6_first", int'(rdy0), 1);
    half2();
    req_valid = '0;
    repeat (8) step();

    // randomized traffic with occasional resets
    for (int j = 0; j < 1500; j++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        en = ($urandom_range(0, 9) != 0);
        req_valid = 4'($urandom);
        rnd_ops();
        step();
      end
    end
    en = 1'b0;
    req_valid = '0;
    repeat (8) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
